// File: rtl/byte_serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add_pkg
//  Description : Shared types and constants for the byte-serial adder.
//                Holds the controller state encoding and the width of the
//                byte counter, sized for the widest legal operand (8 bytes).
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_serial_add_pkg;

    // Widest operand the counter has to index, in bytes.
    localparam int c_max_bytes = 8;

    // Byte counter width: enough to index byte 0 .. c_max_bytes-1.
    localparam int c_cnt_w = $clog2(c_max_bytes);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : byte_serial_add_pkg
`default_nettype wire

// File: rtl/rca_8_bit.sv
`default_nettype none
// ============================================================================
//  Module      : rca_8_bit
//  Description : 8-bit ripple-carry adder, the single shared datapath of the
//                byte-serial adder.
//  Ports       : x, y       - 8-bit addends
//                carry_in   - carry into bit 0
//                sum        - 8-bit sum
//                carry_out  - carry out of bit 7
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_8_bit (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       carry_in,
    output logic [7:0] sum,
    output logic       carry_out
);

    // w_carry[i] is the carry into bit i; w_carry[8] leaves the adder.
    logic [8:0] w_carry;

    assign w_carry[0] = carry_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign sum[gi]         = x[gi] ^ y[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (x[gi] & y[gi]) | (w_carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign carry_out = w_carry[8];

endmodule : rca_8_bit
`default_nettype wire

// File: rtl/byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add_seq
//  Description : Byte-serial add/subtract unit. A request is latched in IDLE,
//                the operands are combined one byte per cycle (LSB first)
//                through a single 8-bit ripple-carry adder, and the result is
//                presented with valid/ready handshaking in DONE.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                in_valid / in_ready   - request handshake
//                a, b, carry_in, sub   - operands, initial carry, op select
//                out_valid / out_ready - result handshake
//                sum, carry_out        - result and final carry
//                overflow              - two's-complement signed overflow
//                busy                  - a transaction is in RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_add_seq
    import byte_serial_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] a,
    input  logic [8*NUM_BYTES-1:0] b,
    input  logic                   carry_in,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] sum,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   busy
);

    localparam int c_w = 8 * NUM_BYTES;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_w-1:0]     r_a;
    logic [c_w-1:0]     r_b;      // effective B: already inverted for subtract
    logic [c_w-1:0]     r_sum;
    logic               r_carry;  // running carry between bytes
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_out_valid;

    logic [7:0]         w_a_byte;
    logic [7:0]         w_b_byte;
    logic [7:0]         w_byte_sum;
    logic               w_byte_cout;
    logic               w_last;

    // Select the operand bytes addressed by the byte counter.
    always_comb begin
        w_a_byte = '0;
        w_b_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
                w_a_byte = r_a[i*8 +: 8];
                w_b_byte = r_b[i*8 +: 8];
            end
        end
    end

    assign w_last = (r_cnt == c_cnt_w'(NUM_BYTES - 1));

    rca_8_bit u_rca (
        .x         (w_a_byte),
        .y         (w_b_byte),
        .carry_in  (r_carry),
        .sum       (w_byte_sum),
        .carry_out (w_byte_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B here and seed the
                        // carry with 1 so the byte loop is identical for both.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : carry_in;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (r_cnt == c_cnt_w'(i)) begin
                            r_sum[i*8 +: 8] <= w_byte_sum;
                        end
                    end
                    r_carry <= w_byte_cout;
                    if (w_last) begin
                        // The top byte's sum bit is the result msb; take it
                        // straight from the adder since r_sum is not yet written.
                        r_carry_out <= w_byte_cout;
                        r_overflow  <= (r_a[c_w-1] == r_b[c_w-1]) &&
                                       (w_byte_sum[7] != r_a[c_w-1]);
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule : byte_serial_add_seq
`default_nettype wire

// File: tb/tb_byte_serial_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_add_seq
//  Description : Self-checking bench for byte_serial_add_seq (4-byte build).
//                A transaction-level model predicts handshake and result
//                behaviour; directed vectors carry hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         carry_in  = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_serial_add_seq #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: unsigned 64-bit math for sum/carry, signed
    // 64-bit math for overflow. Returns {carry, overflow, sum}.
    function automatic logic [W+1:0] model_calc(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                                 input logic fcin, input logic fsub);
        longint unsigned ua, ub, ures;
        longint          sa, sb, sres, smax, smin;
        logic            c, o;
        ua   = 64'(fa);
        ub   = 64'(fb);
        sa   = longint'($signed(fa));
        sb   = longint'($signed(fb));
        smax = (64'sd1 <<< (W - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (W - 1));
        if (fsub) begin
            ures = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + 64'(fcin);
            c    = ((ures >> W) != 0);
            sres = sa + sb + longint'(fcin);
        end
        o = (sres > smax) || (sres < smin);
        return {c, o, ures[W-1:0]};
    endfunction

    // Transaction-level model: a request is taken only when nothing is
    // pending, the result appears NB edges later and is held until taken.
    logic         m_pending = 1'b0;
    int           m_cnt     = 0;
    logic [W-1:0] m_sum     = '0;
    logic         m_c       = 1'b0;
    logic         m_o       = 1'b0;
    logic [W+1:0] m_nxt     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending <= 1'b0;
            m_cnt     <= 0;
            m_sum     <= '0;
            m_c       <= 1'b0;
            m_o       <= 1'b0;
        end else if (!m_pending) begin
            if (in_valid) begin
                m_nxt     <= model_calc(a, b, carry_in, sub);
                m_pending <= 1'b1;
                m_cnt     <= NB;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) {m_c, m_o, m_sum} <= m_nxt;
        end else if (out_ready) begin
            m_pending <= 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cmp_in_ready", 64'(in_ready), 64'(!m_pending));
        check("cmp_busy", 64'(busy), 64'(m_pending));
        check("cmp_out_valid", 64'(out_valid), 64'(m_pending && (m_cnt == 0)));
        if (!(m_pending && (m_cnt != 0))) begin
            check("cmp_sum", 64'(sum), 64'(m_sum));
            check("cmp_carry_out", 64'(carry_out), 64'(m_c));
            check("cmp_overflow", 64'(overflow), 64'(m_o));
        end
    end

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                           input logic tsub, input logic [W-1:0] esum, input logic ec,
                           input logic eo, input int hold, input bit scramble);
        int           n;
        logic [W+1:0] mv;
        mv = model_calc(ta, tb, tcin, tsub);
        check("model_pin_sum", 64'(mv[W-1:0]), 64'(esum));
        check("model_pin_carry", 64'(mv[W+1]), 64'(ec));
        check("model_pin_ovf", 64'(mv[W]), 64'(eo));

        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("wait_in_ready_timeout", 64'(in_ready), 64'd1);

        a = ta; b = tb; carry_in = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (scramble) begin
                a        = $urandom;
                b        = $urandom;
                sub      = 1'($urandom_range(0, 1));
                carry_in = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
        end
        check("latency_edges", 64'(n), 64'(NB));
        check("lit_sum", 64'(sum), 64'(esum));
        check("lit_carry_out", 64'(carry_out), 64'(ec));
        check("lit_overflow", 64'(overflow), 64'(eo));

        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = ~ta;
            b         = ta;
            repeat (hold) begin
                @(negedge clk);
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_sum", 64'(sum), 64'(esum));
                check("hold_carry_out", 64'(carry_out), 64'(ec));
                check("hold_overflow", 64'(overflow), 64'(eo));
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(negedge clk);
            check("release_in_ready", 64'(in_ready), 64'd1);
            check("release_out_valid", 64'(out_valid), 64'd0);
            check("release_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_carry_out", 64'(carry_out), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Carry out of byte 0 into byte 1.
        run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, 1'b0);
        // Carry ripples through every byte and wraps onto carry_out.
        run_txn(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);
        // Subtract with borrow.
        run_txn(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 1'b0);
        // Positive overflow on add.
        run_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0);
        // Consumer stalls 5 cycles; a second request is ignored meanwhile.
        run_txn(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 5, 1'b0);

        // Reset asserted while byte 2 is being processed.
        @(negedge clk);
        a = 32'hCAFE_F00D; b = 32'h1111_1111; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_sum", 64'(sum), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_carry_out", 64'(carry_out), 64'd0);
        check("midrun_rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Clean transaction after reset.
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 0, 1'b0);
        // Inputs scrambled every cycle while running.
        run_txn(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b1, 32'hDD8A_7988, 1'b1, 1'b0, 0, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=%0t required=<100000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_byte_serial_add_seq
`default_nettype wire

// File: doc/byte_serial_add_seq.md
BYTE_SERIAL_ADD_SEQ -- requirements
Module: byte_serial_add_seq

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 4, meaning the operand width in bytes (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, the block can accept a request.
REQ-006 SHALL have port a, input, 8*NUM_BYTES, operand A.
REQ-007 SHALL have port b, input, 8*NUM_BYTES, operand B.
REQ-008 SHALL have port carry_in, input, 1, the initial carry; used for add only.
REQ-009 SHALL have port sub, input, 1, selecting A-B when 1 and A+B+carry_in when 0.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-012 SHALL have port sum, output, 8*NUM_BYTES, the result.
REQ-013 SHALL have port carry_out, output, 1, the final carry (for sub, 1 means no borrow).
REQ-014 SHALL have port overflow, output, 1, the two's-complement signed overflow.
REQ-015 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE.
REQ-018 SHALL, on a clock edge with in_valid&&in_ready: latch a, b, sub and carry_in; clear the byte counter; go to RUN.
REQ-019 SHALL, on the same accepting edge, load the carry register with 1 when sub=1 and with carry_in when sub=0; b SHALL be stored bitwise inverted when sub=1.
REQ-020 SHALL, in RUN cycle k (k=0..NUM_BYTES-1), add byte k of A, byte k of effective B and the carry register through one shared 8-bit adder, then on the edge write sum byte k, update the carry register and increment k.
REQ-021 SHALL process bytes LSB first and use exactly one 8-bit adder instance for every byte.
REQ-022 SHALL, on the edge completing byte NUM_BYTES-1, go to DONE. out_valid SHALL be 1 exactly NUM_BYTES edges after the accepting edge.
REQ-023 SHALL hold sum, carry_out, overflow and out_valid stable in DONE until out_valid&&out_ready, then return to IDLE on that edge.
REQ-024 SHALL compute overflow as (A msb == effective-B msb) && (sum msb != A msb).
REQ-025 SHALL keep sum, carry_out and overflow at their last values in IDLE, and SHALL drive out_valid=0 outside DONE.
REQ-026 SHALL ignore in_valid outside IDLE; no request is queued.
REQ-027 SHALL not let a change of inputs a, b, sub or carry_in after acceptance affect the result in progress.
REQ-028 SHALL produce a result modulo 2^(8*NUM_BYTES); carry wrap-around out of the top byte SHALL appear only on carry_out.

Reset
REQ-029 SHALL, when rst_n=0 (asynchronous, at any time including mid-RUN), force IDLE, byte counter=0, carry register=0, sum=0, carry_out=0, overflow=0 and out_valid=0; any in-flight transaction SHALL be dropped.
REQ-030 SHALL drive in_ready=1 and busy=0 while in reset and after reset is released.

Structure
REQ-031 SHALL define the FSM state encoding and the byte-count width constant in the shared package byte_serial_add_pkg.
REQ-032 SHALL instantiate one sub-module rca_8_bit (8-bit ripple-carry adder: x, y, carry_in -> sum, carry_out) as the shared datapath.

Verification
REQ-033 The bench SHALL cover: add with NUM_BYTES=4, a=0x000000FF, b=0x00000001, carry_in=0 -> sum=0x00000100, carry_out=0, overflow=0, out_valid 4 edges after acceptance.
REQ-034 The bench SHALL cover: add with a=0xFFFFFFFF, b=0x00000000, carry_in=1 -> sum=0x00000000, carry_out=1, overflow=0 (full carry ripple across all bytes).
REQ-035 The bench SHALL cover: sub with a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, carry_out=0 (borrow); and add with a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, overflow=1.
REQ-036 The bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, a second in_valid ignored; then out_ready=1 -> IDLE next edge.
REQ-037 The bench SHALL cover: rst_n pulsed low during RUN byte 2 -> out_valid=0, sum=0 immediately, in_ready=1; a following request completes correctly.
REQ-038 The bench SHALL cover: a/b changed every cycle during RUN -> the result matches the operands latched at acceptance.
